// File: rtl/key_press_encoder.sv
// Four-button front end: two-flop synchroniser, per-key debounce, press-edge
// detection and single-key acceptance into a registered one-hot code.
module key_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  input  logic       enable,
  output logic [3:0] onehot,
  output logic       press_valid,
  output logic       multi_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         sync_p0;
  logic [3:0]         sync_p1;
  logic [3:0]         pressed_s;
  logic [3:0]         deb;
  logic [3:0]         deb_next;
  logic [3:0]         rise;
  logic [3:0][CW-1:0] cnt;
  logic [3:0][CW-1:0] cnt_next;
  logic               accept;
  logic               reject;

  // Stage 0/1: synchronise the asynchronous buttons; sync flops idle released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 4'b1111;
      sync_p1 <= 4'b1111;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_s = ~sync_p1;

  // Stage 2: a state change needs DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_next = deb;
    rise     = 4'b0000;
    cnt_next = '0;
    for (int i = 0; i < 4; i++) begin
      if (pressed_s[i] != deb[i]) begin
        if (cnt[i] == LAST) begin
          deb_next[i] = pressed_s[i];
          rise[i]     = pressed_s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is unambiguous only if it is the sole rising key and nothing is held.
  assign accept = enable && $onehot(rise) && (deb == 4'b0000);
  assign reject = enable && (rise != 4'b0000) && !accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb         <= 4'b0000;
      cnt         <= '0;
      onehot      <= 4'b0000;
      press_valid <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      deb         <= deb_next;
      cnt         <= cnt_next;
      press_valid <= accept;
      multi_press <= reject;
      if (accept) begin
        onehot <= rise;
      end
    end
  end

endmodule

// File: tb/tb_key_press_encoder.sv
// Bench for key_press_encoder: directed vector table, reset corner sequence and
// random stimulus against a sample-window reference model.
module tb_key_press_encoder;

  localparam int D = 4;

  logic       clock;
  logic       reset_n;
  logic [3:0] key_n;
  logic       enable;
  logic [3:0] onehot;
  logic       press_valid;
  logic       multi_press;

  key_press_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .enable      (enable),
    .onehot      (onehot),
    .press_valid (press_valid),
    .multi_press (multi_press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] key;
    logic       en;
    logic [3:0] oh;
    logic       pv;
    logic       mp;
  } row_t;

  row_t       rows[$];
  logic [3:0] cur_oh;

  // Reference model: raw samples reach the debouncer two edges late; a key's
  // state flips once the last D seen samples all disagree with it.
  logic [3:0] dq[$];
  logic [3:0] seen[$];
  logic [3:0] m_deb;
  logic [3:0] m_oh;
  logic       m_pv;
  logic       m_mp;

  task automatic model_reset();
    dq.delete();
    dq.push_back(4'hF);
    dq.push_back(4'hF);
    seen.delete();
    m_deb = 4'h0;
    m_oh  = 4'h0;
    m_pv  = 1'b0;
    m_mp  = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] now;
    logic [3:0] flip;
    logic [3:0] rs;
    bit         all_diff;
    now = ~dq.pop_front();
    dq.push_back(key_n);
    seen.push_back(now);
    if (seen.size() > D) void'(seen.pop_front());
    flip = 4'h0;
    if (seen.size() == D) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < seen.size(); j++)
          if (seen[j][i] == m_deb[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
    end
    rs   = flip & now;
    m_pv = 1'b0;
    m_mp = 1'b0;
    if (enable && rs != 4'h0) begin
      if ($countones(rs) == 1 && m_deb == 4'h0) begin
        m_oh = rs;
        m_pv = 1'b1;
      end else begin
        m_mp = 1'b1;
      end
    end
    m_deb = m_deb ^ flip;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    check("model_onehot", onehot, m_oh);
    check("model_press_valid", {3'b000, press_valid}, {3'b000, m_pv});
    check("model_multi_press", {3'b000, multi_press}, {3'b000, m_mp});
  endtask

  // n rows of constant inputs; any pulse is expected on the last row only.
  task automatic seg(input logic [3:0] k, input logic en, input int n,
                     input logic [3:0] new_oh, input logic pv, input logic mp);
    row_t r;
    for (int j = 0; j < n; j++) begin
      r.key = k;
      r.en  = en;
      r.pv  = (j == n - 1) && pv;
      r.mp  = (j == n - 1) && mp;
      r.oh  = ((j == n - 1) && pv) ? new_oh : cur_oh;
      rows.push_back(r);
    end
    if (pv) cur_oh = new_oh;
  endtask

  initial begin
    int         hold;
    int         idx;
    logic [3:0] k;

    reset_n = 1'b1;
    key_n   = 4'hF;
    enable  = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check("reset_onehot", onehot, 4'h0);
    check("reset_press_valid", {3'b000, press_valid}, 4'h0);
    check("reset_multi_press", {3'b000, multi_press}, 4'h0);
    #10 reset_n = 1'b1;

    cur_oh = 4'h0;
    // clean press of key 0, then release
    seg(4'b1110, 1'b1, 6, 4'b0001, 1'b1, 1'b0);
    seg(4'b1110, 1'b1, 1, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 8, 4'b0000, 1'b0, 1'b0);
    // bounce on key 2, then a genuine hold
    seg(4'b1011, 1'b1, 3, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 1, 4'b0000, 1'b0, 1'b0);
    seg(4'b1011, 1'b1, 3, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 3, 4'b0000, 1'b0, 1'b0);
    seg(4'b1011, 1'b1, 6, 4'b0100, 1'b1, 1'b0);
    seg(4'b1011, 1'b1, 1, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 8, 4'b0000, 1'b0, 1'b0);
    // two keys together
    seg(4'b1100, 1'b1, 6, 4'b0000, 1'b0, 1'b1);
    seg(4'b1100, 1'b1, 1, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 8, 4'b0000, 1'b0, 1'b0);
    // key 0 held, then key 3 added
    seg(4'b1110, 1'b1, 6, 4'b0001, 1'b1, 1'b0);
    seg(4'b0110, 1'b1, 6, 4'b0000, 1'b0, 1'b1);
    seg(4'b0110, 1'b1, 1, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 8, 4'b0000, 1'b0, 1'b0);
    // enable gating on key 1
    seg(4'b1101, 1'b0, 7, 4'b0000, 1'b0, 1'b0);
    seg(4'b1101, 1'b1, 4, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 8, 4'b0000, 1'b0, 1'b0);
    seg(4'b1101, 1'b1, 6, 4'b0010, 1'b1, 1'b0);
    seg(4'b1101, 1'b1, 1, 4'b0000, 1'b0, 1'b0);
    seg(4'b1111, 1'b1, 8, 4'b0000, 1'b0, 1'b0);

    for (int r = 0; r < rows.size(); r++) begin
      key_n  = rows[r].key;
      enable = rows[r].en;
      tick();
      check($sformatf("vec%0d_onehot", r), onehot, rows[r].oh);
      check($sformatf("vec%0d_press_valid", r), {3'b000, press_valid}, {3'b000, rows[r].pv});
      check($sformatf("vec%0d_multi_press", r), {3'b000, multi_press}, {3'b000, rows[r].mp});
    end

    // key 3 pressed, reset asserted mid-debounce while still held
    key_n  = 4'b0111;
    enable = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("pre_reset_no_pulse", {3'b000, press_valid}, 4'h0);
    end
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_onehot", onehot, 4'h0);
    check("async_reset_press_valid", {3'b000, press_valid}, 4'h0);
    check("async_reset_multi_press", {3'b000, multi_press}, 4'h0);
    model_reset();
    tick();
    tick();
    #2 reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("post_reset_e%0d_press_valid", e), {3'b000, press_valid},
            (e == 6) ? 4'h1 : 4'h0);
      check($sformatf("post_reset_e%0d_onehot", e), onehot, (e >= 6) ? 4'b1000 : 4'b0000);
    end
    key_n = 4'hF;
    for (int e = 0; e < 8; e++) tick();

    // random stimulus, checked every cycle by the model inside tick()
    for (int s = 0; s < 400; s++) begin
      k = 4'hF;
      case ($urandom_range(0, 3))
        0: k = 4'hF;
        1, 2: begin
          idx = $urandom_range(0, 3);
          k[idx] = 1'b0;
        end
        default: k = 4'($urandom_range(0, 15));
      endcase
      key_n  = k;
      enable = ($urandom_range(0, 4) != 0);
      hold   = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
